mac_requant_pack: RTL
=====================

Name: mac_requant_pack

Overview:
- Back end of the MAC datapath: consumes signed 32-bit partial sums from the 4-lane int8 MAC array and produces uint8 activations for the next layer.
- Accumulates partial sums over one dot-product, delimited by a last flag.
- Applies bias, a rounding arithmetic right shift, ReLU and clamp to 0..255.
- Packs four result bytes into one 32-bit word returned to the coprocessor result path.

Parameters:
- NBYTES, 4, result bytes per output word. Output word width is 8*NBYTES. Only 4 is verified.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- psum_valid_i  in  1  partial-sum beat valid
- psum_ready_o  out  1  partial-sum beat accepted when valid and ready are both high
- psum_i  in  32  signed partial sum
- psum_last_i  in  1  beat closes the current dot-product
- bias_i  in  32  signed bias; must be stable while busy_o is high
- shift_i  in  5  right-shift amount, 0..31; must be stable while busy_o is high
- flush_i  in  1  single-cycle pulse: emit any partially packed word
- word_valid_o  out  1  packed word valid
- word_ready_i  in  1  downstream accepts the word
- word_o  out  8*NBYTES  packed bytes, byte0 in bits [7:0]
- word_be_o  out  NBYTES  valid-byte mask
- busy_o  out  1  accumulator or pack register non-empty, or a flush is pending

Behaviour:
- Reset (async, rst_ni=0):
  - State ACC; acc=0; beat count=0; pack count=0; pack data=0; flush pending=0.
  - Outputs: word_valid_o=0, word_o=0, word_be_o=0, busy_o=0, psum_ready_o=1 once released.
  - Asserting reset mid-operation discards all accumulated and packed data; nothing is emitted.
- States:
  - ACC: psum_ready_o=1.
    - On an accepted beat: acc <= sat32(acc + psum_i), where sat32 saturates to 0x7FFFFFFF / 0x80000000.
    - If psum_last_i is high on that beat, go to REQ.
  - REQ (one cycle, psum_ready_o=0):
    - s = acc + bias_i, computed at 34 bits with no saturation.
    - r = (s + (shift_i ? 2^(shift_i-1) : 0)) >>> shift_i, arithmetic shift.
    - byte = 0 if r<0; 255 if r>255; otherwise r[7:0].
    - The byte is written into lane [pack count]; pack count++; acc <= 0.
    - If pack count reaches NBYTES, go to OUT; otherwise go to ACC.
  - OUT: word_valid_o=1, word_o=pack data, word_be_o = mask of filled lanes; psum_ready_o=0.
    - On word_ready_i: clear pack data and count, deassert valid next cycle, go to ACC.
    - word_o and word_be_o are held stable while valid and not ready.
- Latency: last beat accepted at cycle t → byte written at end of t+1 → word_valid_o high from t+2 when it is the 4th byte. Minimum dot-product period is 2 cycles.
- Flush:
  - flush_i sets flush pending; it is never lost, even if it coincides with a beat.
  - Serviced in ACC only when the beat count is 0 (no dot-product in progress) and no beat is accepted that cycle.
  - Pack count>0: go to OUT with a partial word_be_o, e.g. 4'b0011. Pack count=0: just clear pending.
  - Pending clears on entry to OUT.
- Simultaneous events: a beat accepted in ACC and flush_i in the same cycle means the beat is processed and the flush stays pending.
- A beat with psum_last_i=1 as the first beat of a dot-product is legal: it is a single-beat dot-product.

Decomposition:
- Shared package mac_pkg holds:
  - constants ACC_W=32, ACT_W=8, SHIFT_W=5
  - state enum mac_rq_state_e {ACC, REQ, OUT}
  - function sat_add32
- One sub-module, mac_requant, is purely combinational: acc, bias, shift → byte (34-bit sum, rounding, ReLU, clamp). It is unit-tested standalone.
- The FSM, accumulator and packer stay in the top module.

Test Plan:
- Basic pack: beats 100, 200, 300(last), bias=0, shift=2 → byte (600+2)>>2 = 150. Repeat 4× → word_o=0x96969696, word_be_o=0xF, valid 2 cycles after the final last beat.
- ReLU/clamp: single-beat -500, bias=0, shift=0 → 0x00. Single-beat 70000, shift=0 → 0xFF. Acc 10, bias=-1, shift=0 → 0x09.
- Rounding: acc 6, shift=2 → 2; acc 5, shift=2 → 1; acc -3, bias=0 → 0x00.
- Saturation: 0x7FFFFFFF, 0x7FFFFFFF(last) → acc stays 0x7FFFFFFF; bias=1, shift=24 → byte 0x80 (no 32-bit wrap in the 34-bit sum).
- Flush: dot-products yielding 0x11 and 0x22, then flush_i pulse → word_o=0x00002211, word_be_o=0x3. A flush pulsed during a beat is serviced only after that dot-product's last beat.
- Back-pressure and reset:
  - Hold word_ready_i=0 for 5 cycles: word_o and word_be_o are stable and psum_ready_o=0.
  - Assert rst_ni=0 mid-OUT: word_valid_o=0 immediately, busy_o=0, the next word starts at lane 0.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types, widths and helpers for the MAC back end (accumulate, requantise, pack).
package mac_pkg;

  localparam int unsigned ACC_W   = 32;
  localparam int unsigned ACT_W   = 8;
  localparam int unsigned SHIFT_W = 5;
  localparam int unsigned SUM_W   = ACC_W + 2;

  typedef enum logic [1:0] {
    ACC,
    REQ,
    OUT
  } mac_rq_state_e;

  // Signed 32-bit add that clamps to the int32 range instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_add32(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    s = a + b;
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
      sat_add32 = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sat_add32 = s;
    end
  endfunction

endpackage

// File: rtl/mac_requant.sv
// Combinational requantiser: bias add at 34 bits, round-half-up arithmetic shift,
// ReLU and clamp to an unsigned 8-bit activation.
module mac_requant
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [ACC_W-1:0]   bias_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [ACT_W-1:0]   act_o
);

  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] rnd_c;
  logic signed [SUM_W-1:0] shr_c;

  always_comb begin
    sum_c = $signed({{2{acc_i[ACC_W-1]}}, acc_i}) + $signed({{2{bias_i[ACC_W-1]}}, bias_i});
    rnd_c = '0;
    if (shift_i != '0) begin
      rnd_c = SUM_W'(1) << (shift_i - SHIFT_W'(1));
    end
    shr_c = (sum_c + rnd_c) >>> shift_i;
    // Negative saturates to 0, anything above 255 to 255.
    if (shr_c[SUM_W-1]) begin
      act_o = '0;
    end else if (|shr_c[SUM_W-2:ACT_W]) begin
      act_o = '1;
    end else begin
      act_o = shr_c[ACT_W-1:0];
    end
  end

endmodule

// File: rtl/mac_requant_pack.sv
// MAC back end: accumulates partial sums per dot-product, requantises each result
// to uint8 and packs NBYTES results per output word, with an explicit flush.
module mac_requant_pack
  import mac_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      psum_valid_i,
  output logic                      psum_ready_o,
  input  logic [ACC_W-1:0]          psum_i,
  input  logic                      psum_last_i,
  input  logic [ACC_W-1:0]          bias_i,
  input  logic [SHIFT_W-1:0]        shift_i,
  input  logic                      flush_i,
  output logic                      word_valid_o,
  input  logic                      word_ready_i,
  output logic [ACT_W*NBYTES-1:0]   word_o,
  output logic [NBYTES-1:0]         word_be_o,
  output logic                      busy_o
);

  localparam int unsigned WORD_W = ACT_W * NBYTES;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  mac_rq_state_e     state_q;
  logic [ACC_W-1:0]  acc_q;
  logic              open_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] pack_q;
  logic [NBYTES-1:0] be_q;
  logic              flush_q;
  logic              valid_q;
  logic              ready_q;
  logic              busy_q;

  logic [ACT_W-1:0]  act_c;
  logic              beat_c;
  logic              pend_c;
  logic              last_lane_c;

  mac_requant u_requant (
    .acc_i   (acc_q),
    .bias_i  (bias_i),
    .shift_i (shift_i),
    .act_o   (act_c)
  );

  assign beat_c      = psum_valid_i & ready_q;
  assign pend_c      = flush_q | flush_i;
  assign last_lane_c = (cnt_q == CNT_W'(NBYTES - 1));

  // Control FSM with accumulator and packer; every output is a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACC;
      acc_q   <= '0;
      open_q  <= 1'b0;
      cnt_q   <= '0;
      pack_q  <= '0;
      be_q    <= '0;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (beat_c) begin
            // A flush arriving with a beat waits until the dot-product closes.
            acc_q   <= sat_add32(acc_q, psum_i);
            flush_q <= pend_c;
            busy_q  <= 1'b1;
            if (psum_last_i) begin
              open_q  <= 1'b0;
              ready_q <= 1'b0;
              state_q <= REQ;
            end else begin
              open_q <= 1'b1;
            end
          end else if (pend_c && !open_q) begin
            flush_q <= 1'b0;
            if (cnt_q != '0) begin
              valid_q <= 1'b1;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= OUT;
            end else begin
              busy_q <= 1'b0;
            end
          end else begin
            flush_q <= pend_c;
            busy_q  <= open_q | (cnt_q != '0) | pend_c;
          end
        end

        REQ: begin
          for (int unsigned l = 0; l < NBYTES; l++) begin
            if (cnt_q == CNT_W'(l)) begin
              pack_q[l*ACT_W +: ACT_W] <= act_c;
              be_q[l]                  <= 1'b1;
            end
          end
          cnt_q  <= cnt_q + CNT_W'(1);
          acc_q  <= '0;
          busy_q <= 1'b1;
          if (last_lane_c) begin
            flush_q <= 1'b0;
            valid_q <= 1'b1;
            state_q <= OUT;
          end else begin
            flush_q <= pend_c;
            ready_q <= 1'b1;
            state_q <= ACC;
          end
        end

        OUT: begin
          flush_q <= pend_c;
          if (word_ready_i) begin
            pack_q  <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= pend_c;
            state_q <= ACC;
          end
        end

        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          state_q <= ACC;
        end
      endcase
    end
  end

  assign psum_ready_o = ready_q;
  assign word_valid_o = valid_q;
  assign word_o       = pack_q;
  assign word_be_o    = be_q;
  assign busy_o       = busy_q;

endmodule
